uart_cmd_assembler: RTL and testbench
=====================================

Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes received bytes via the receiver's rx_rdy / rx_data / rx_rdy_clr handshake and assembles them into 24-bit command frames: opcode byte, then data high byte, then data low byte.
- Presents each completed command to the command-processing logic with a level ready flag and a clear input.
- Detects inter-byte timeouts and command overruns.

Parameters:
- TIMEOUT, 104160: clk cycles of inter-byte silence mid-frame before the partial frame is discarded (4 byte-times at 2604 clks/bit).
- TO_W, 17: width of the gap counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  50MHz system clock
- rst_n  input  1  asynchronous active-low reset
- rx_rdy  input  1  byte-available flag from the UART receiver
- rx_data  input  8  received byte, valid while rx_rdy=1
- clr_cmd_rdy  input  1  consumer acknowledges cmd; clears cmd_rdy and overrun
- rx_rdy_clr  output  1  one-cycle pulse telling the receiver the byte was taken
- cmd  output  24  assembled command {opcode, data_hi, data_lo}
- cmd_rdy  output  1  level; high while cmd holds an unacknowledged command
- overrun  output  1  sticky; a new command overwrote an unacknowledged one
- frame_to  output  1  one-cycle pulse; partial frame discarded on timeout

Behaviour:
- Reset: clk and rst_n are one clock, asynchronous active-low reset. All outputs 0, cmd=24'h000000, state=IDLE, gap counter 0, rx_rdy edge flop 0.
- Byte accept:
  - Accept event = rx_rdy & ~rx_rdy_q, where rx_rdy_q is rx_rdy registered.
  - rx_data is captured in the accept cycle.
  - rx_rdy_clr is a registered pulse high exactly the cycle after accept, for one cycle.
  - A rx_rdy held high is accepted only once.
- States:
  - IDLE, accept -> store opcode, go to GOT1.
  - GOT1, accept -> store data_hi, go to GOT2.
  - GOT2, accept -> store data_lo, load cmd, go to IDLE (CHK when CMD_CHKSUM_EN).
  - Default/illegal state -> IDLE.
- Latency: cmd and cmd_rdy update on the clock edge ending the final-byte accept cycle, i.e. visible 1 cycle after accept. cmd is never modified except on frame completion.
- Gap counter:
  - Cleared on every accept and whenever state=IDLE.
  - Otherwise increments, saturating at TIMEOUT.
  - In GOT1/GOT2 with counter==TIMEOUT and no accept this cycle: go to IDLE, pulse frame_to for 1 cycle; partial bytes are discarded; cmd, cmd_rdy and overrun are unchanged.
  - Accept and timeout in the same cycle: accept wins, no frame_to.
- cmd_rdy:
  - Set on frame completion; cleared by clr_cmd_rdy.
  - Completion and clr_cmd_rdy in the same cycle: cmd_rdy stays 1 with the new cmd, no overrun.
- overrun:
  - Set when a frame completes while cmd_rdy=1 and clr_cmd_rdy=0; cmd is overwritten with the new frame.
  - Cleared by clr_cmd_rdy unless it is set again in the same cycle.
- clr_cmd_rdy while cmd_rdy=0: no effect.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: CMD_CHKSUM_EN. Without it, frames are 3 bytes and the CHK state and chk_err port do not exist.
- With it:
  - Frames are 4 bytes; GOT2 accept goes to CHK.
  - CHK accept checks byte == ~(opcode + data_hi + data_lo), sum mod 256.
  - Match: complete exactly as described above.
  - Mismatch: discard frame, leave cmd/cmd_rdy/overrun unchanged, pulse added output chk_err (1 bit) for one cycle.
  - Timeout applies in CHK as in GOT1/GOT2.

Test Plan:
- Bytes 0xA5, 0x12, 0x34 spaced 26040 clks -> cmd=24'hA51234, cmd_rdy=1 one cycle after third accept, one rx_rdy_clr pulse per byte, overrun=0.
- rx_rdy held high 50 cycles on byte 0x01 -> exactly one accept, one rx_rdy_clr pulse, state GOT1.
- Send 0x01, then silence TIMEOUT+5 cycles -> frame_to pulses once, state IDLE; following 0x02, 0x03, 0x04 -> cmd=24'h020304.
- Frame 0x111111 not cleared, then frame 0x222222 -> cmd=24'h222222, overrun=1; clr_cmd_rdy -> cmd_rdy=0, overrun=0. Repeat with clr_cmd_rdy coincident with completion -> cmd_rdy=1, overrun=0.
- Assert rst_n=0 after byte 2 of a frame, release, send 0x0A, 0x0B, 0x0C -> cmd=24'h0A0B0C, no stale bytes.
- CMD_CHKSUM_EN: bytes 0x10, 0x20, 0x30, 0x9F -> cmd=24'h102030, cmd_rdy=1. Checksum byte 0x00 instead -> chk_err pulse, cmd_rdy unchanged.

Source files
------------

// File: rtl/uart_cmd_assembler_if.sv
// Byte-receiver handshake and command-consumer bus for uart_cmd_assembler.
// chk_err exists only when CMD_CHKSUM_EN is defined.
interface uart_cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        rx_rdy_clr;
  logic        clr_cmd_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        overrun;
  logic        frame_to;
`ifdef CMD_CHKSUM_EN
  logic        chk_err;
`endif

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output rx_rdy_clr, cmd, cmd_rdy, overrun, frame_to
`ifdef CMD_CHKSUM_EN
    , output chk_err
`endif
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  rx_rdy_clr, cmd, cmd_rdy, overrun, frame_to
`ifdef CMD_CHKSUM_EN
    , input chk_err
`endif
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Assembles UART bytes into 24-bit {opcode, data_hi, data_lo} commands with gap timeout.
// Define CMD_CHKSUM_EN to add a trailing checksum byte and the chk_err pulse.
module uart_cmd_assembler #(
  parameter int TIMEOUT = 104160,
  parameter int TO_W    = 17
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_cmd_assembler_if.slave io
);

`ifdef CMD_CHKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GOT1 = 2'd1, GOT2 = 2'd2, CHK = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GOT1 = 2'd1, GOT2 = 2'd2} state_e;
`endif

  localparam logic [TO_W-1:0] GAP_MAX = TO_W'(TIMEOUT);

`ifdef CMD_CHKSUM_EN
  function automatic logic [7:0] chk_byte(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] sum;
    sum = a + b + c;
    return ~sum;
  endfunction
`endif

  state_e            state_q, state_d;
  logic              rx_rdy_q;
  logic [TO_W-1:0]   gap_q, gap_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        hi_q, hi_d;
`ifdef CMD_CHKSUM_EN
  logic [7:0]        lo_q, lo_d;
  logic              chk_err_q, chk_err_d;
`endif
  logic [23:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              overrun_q, overrun_d;
  logic              rx_rdy_clr_q;
  logic              frame_to_q, frame_to_d;
  logic              accept_s;
  logic              timeout_s;
  logic              complete_s;
  logic [23:0]       new_cmd_s;

  // Rising edge of rx_rdy: a level held high is taken once.
  assign accept_s  = io.rx_rdy & ~rx_rdy_q;
  assign timeout_s = (state_q != IDLE) && (gap_q == GAP_MAX) && !accept_s;

  // Frame FSM next state, gap counter and command/status next values.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
`ifdef CMD_CHKSUM_EN
    lo_d       = lo_q;
    chk_err_d  = 1'b0;
`endif
    frame_to_d = 1'b0;
    complete_s = 1'b0;
    new_cmd_s  = cmd_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    overrun_d  = overrun_q;
    gap_d      = gap_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = io.rx_data;
          state_d = GOT1;
        end else begin
          state_d = IDLE;
        end
      end
      GOT1: begin
        if (accept_s) begin
          hi_d    = io.rx_data;
          state_d = GOT2;
        end else if (timeout_s) begin
          frame_to_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = GOT1;
        end
      end
      GOT2: begin
        if (accept_s) begin
`ifdef CMD_CHKSUM_EN
          lo_d    = io.rx_data;
          state_d = CHK;
`else
          complete_s = 1'b1;
          new_cmd_s  = {op_q, hi_q, io.rx_data};
          state_d    = IDLE;
`endif
        end else if (timeout_s) begin
          frame_to_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = GOT2;
        end
      end
`ifdef CMD_CHKSUM_EN
      CHK: begin
        if (accept_s) begin
          if (io.rx_data == chk_byte(op_q, hi_q, lo_q)) begin
            complete_s = 1'b1;
            new_cmd_s  = {op_q, hi_q, lo_q};
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = IDLE;
        end else if (timeout_s) begin
          frame_to_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = CHK;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_s || (state_q == IDLE)) begin
      gap_d = {TO_W{1'b0}};
    end else if (gap_q == GAP_MAX) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + TO_W'(1);
    end

    // A coincident acknowledge consumes the old command, so no overrun.
    if (complete_s) begin
      cmd_d     = new_cmd_s;
      cmd_rdy_d = 1'b1;
      if (cmd_rdy_q && !io.clr_cmd_rdy) begin
        overrun_d = 1'b1;
      end else if (io.clr_cmd_rdy) begin
        overrun_d = 1'b0;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (io.clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
      overrun_d = overrun_q;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_rdy_q     <= 1'b0;
      gap_q        <= {TO_W{1'b0}};
      op_q         <= 8'h00;
      hi_q         <= 8'h00;
`ifdef CMD_CHKSUM_EN
      lo_q         <= 8'h00;
      chk_err_q    <= 1'b0;
`endif
      cmd_q        <= 24'h000000;
      cmd_rdy_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rx_rdy_clr_q <= 1'b0;
      frame_to_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_rdy_q     <= io.rx_rdy;
      gap_q        <= gap_d;
      op_q         <= op_d;
      hi_q         <= hi_d;
`ifdef CMD_CHKSUM_EN
      lo_q         <= lo_d;
      chk_err_q    <= chk_err_d;
`endif
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      overrun_q    <= overrun_d;
      rx_rdy_clr_q <= accept_s;
      frame_to_q   <= frame_to_d;
    end
  end

  assign io.rx_rdy_clr = rx_rdy_clr_q;
  assign io.cmd        = cmd_q;
  assign io.cmd_rdy    = cmd_rdy_q;
  assign io.overrun    = overrun_q;
  assign io.frame_to   = frame_to_q;
`ifdef CMD_CHKSUM_EN
  assign io.chk_err    = chk_err_q;
`endif

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: frame table with scoreboard plus
// hand sequences for held rx_rdy, timeout boundary, reset mid-frame and checksum.
module tb_uart_cmd_assembler;
  localparam int TO  = 40;
  localparam int TW  = 6;
  localparam int GAP = 10;
`ifdef CMD_CHKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  typedef struct {
    logic        pre_clr;
    logic        clr_last;
    logic [7:0]  op;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [23:0] exp_cmd;
    logic        exp_rdy;
    logic        exp_ovr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_assembler_if io();

  uart_cmd_assembler #(.TIMEOUT(TO), .TO_W(TW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  int checks = 0;
  int errors = 0;
  int clr_pulses = 0;
  int to_pulses = 0;
  int chk_pulses = 0;
  logic [23:0] exp_q[$];
  vec_t vecs[8];

  always @(posedge clk) begin
    if (io.rx_rdy_clr === 1'b1) clr_pulses++;
    if (io.frame_to === 1'b1) to_pulses++;
`ifdef CMD_CHKSUM_EN
    if (io.chk_err === 1'b1) chk_pulses++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input logic clr);
    @(negedge clk);
    io.rx_rdy = 1'b1;
    io.rx_data = b;
    io.clr_cmd_rdy = clr;
    @(negedge clk);
    io.clr_cmd_rdy = 1'b0;
    repeat (hold - 1) @(negedge clk);
    io.rx_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    io.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    io.clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                            input logic clr_last);
    logic [7:0] s;
    s = op + hi + lo;
    send_byte(op, 1, 1'b0);
    idle(GAP);
    send_byte(hi, 1, 1'b0);
    idle(GAP);
`ifdef CMD_CHKSUM_EN
    send_byte(lo, 1, 1'b0);
    idle(GAP);
    send_byte(~s, 1, clr_last);
`else
    send_byte(lo, 1, clr_last);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] got;
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h12, 8'h34, 24'hA51234, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h11, 8'h11, 8'h11, 24'h111111, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h22, 8'h22, 8'h22, 24'h222222, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h33, 8'h33, 8'h33, 24'h333333, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h44, 8'h44, 8'h44, 24'h444444, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h55, 8'h66, 8'h77, 24'h556677, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 24'hFF00FF, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 24'h000000, 1'b1, 1'b0};

    io.rx_rdy = 1'b0;
    io.rx_data = 8'h00;
    io.clr_cmd_rdy = 1'b0;
    idle(3);
    check("reset_cmd", 32'(io.cmd), 32'h0);
    check("reset_rdy", 32'(io.cmd_rdy), 32'h0);
    check("reset_ovr", 32'(io.overrun), 32'h0);
    check("reset_clr", 32'(io.rx_rdy_clr), 32'h0);
    check("reset_to", 32'(io.frame_to), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Latency: cmd_rdy must still be low just before the final accept.
    clr_pulses = 0;
    send_byte(8'h5A, 1, 1'b0);
    idle(GAP);
    send_byte(8'h01, 1, 1'b0);
    idle(GAP);
`ifdef CMD_CHKSUM_EN
    send_byte(8'h02, 1, 1'b0);
    idle(GAP);
    check("lat_pre_rdy", 32'(io.cmd_rdy), 32'h0);
    send_byte(8'hA2, 1, 1'b0);
`else
    check("lat_pre_rdy", 32'(io.cmd_rdy), 32'h0);
    send_byte(8'h02, 1, 1'b0);
`endif
    check("lat_rdy", 32'(io.cmd_rdy), 32'h1);
    check("lat_cmd", 32'(io.cmd), 32'h5A0102);
    idle(2);
    check("lat_clr_pulses", 32'(clr_pulses), 32'(FLEN));

    to_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_clr) begin
        pulse_clr();
        check($sformatf("v%0d_preclr_rdy", i), 32'(io.cmd_rdy), 32'h0);
        check($sformatf("v%0d_preclr_ovr", i), 32'(io.overrun), 32'h0);
      end
      clr_pulses = 0;
      exp_q.push_back(vecs[i].exp_cmd);
      send_frame(vecs[i].op, vecs[i].hi, vecs[i].lo, vecs[i].clr_last);
      got = exp_q.pop_front();
      check($sformatf("v%0d_cmd", i), 32'(io.cmd), 32'(got));
      check($sformatf("v%0d_rdy", i), 32'(io.cmd_rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("v%0d_ovr", i), 32'(io.overrun), 32'(vecs[i].exp_ovr));
      idle(2);
      check($sformatf("v%0d_clr_pulses", i), 32'(clr_pulses), 32'(FLEN));
    end
    check("table_no_timeout", 32'(to_pulses), 32'h0);

    // rx_rdy held high: one accept only, then the frame continues from GOT1.
    pulse_clr();
    clr_pulses = 0;
    send_byte(8'h01, 20, 1'b0);
    idle(GAP);
    check("held_clr_pulses", 32'(clr_pulses), 32'h1);
    send_byte(8'h02, 1, 1'b0);
    idle(GAP);
`ifdef CMD_CHKSUM_EN
    send_byte(8'h03, 1, 1'b0);
    idle(GAP);
    send_byte(8'hF9, 1, 1'b0);
`else
    send_byte(8'h03, 1, 1'b0);
`endif
    check("held_cmd", 32'(io.cmd), 32'h010203);

    // Timeout discards the partial frame, next frame assembles cleanly.
    pulse_clr();
    to_pulses = 0;
    send_byte(8'h01, 1, 1'b0);
    idle(TO + 5);
    check("to_pulses", 32'(to_pulses), 32'h1);
    check("to_rdy_kept", 32'(io.cmd_rdy), 32'h0);
    exp_q.push_back(24'h020304);
    send_frame(8'h02, 8'h03, 8'h04, 1'b0);
    got = exp_q.pop_front();
    check("to_next_cmd", 32'(io.cmd), 32'(got));
    check("to_pulses_after", 32'(to_pulses), 32'h1);

    // Accept lands in the exact timeout cycle: accept wins.
    to_pulses = 0;
    send_byte(8'h07, 1, 1'b0);
    idle(TO - 1);
    send_byte(8'h08, 1, 1'b0);
    idle(GAP);
`ifdef CMD_CHKSUM_EN
    send_byte(8'h09, 1, 1'b0);
    idle(GAP);
    send_byte(8'hE7, 1, 1'b0);
`else
    send_byte(8'h09, 1, 1'b0);
`endif
    idle(2);
    check("edge_no_to", 32'(to_pulses), 32'h0);
    check("edge_cmd", 32'(io.cmd), 32'h070809);

    // Reset mid-frame loses the partial bytes.
    send_byte(8'h55, 1, 1'b0);
    idle(GAP);
    send_byte(8'h66, 1, 1'b0);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    check("rst_mid_cmd", 32'(io.cmd), 32'h0);
    check("rst_mid_rdy", 32'(io.cmd_rdy), 32'h0);
    check("rst_mid_ovr", 32'(io.overrun), 32'h0);
    rst_n = 1'b1;
    idle(2);
    exp_q.push_back(24'h0A0B0C);
    send_frame(8'h0A, 8'h0B, 8'h0C, 1'b0);
    got = exp_q.pop_front();
    check("rst_next_cmd", 32'(io.cmd), 32'(got));
    check("rst_next_ovr", 32'(io.overrun), 32'h0);

`ifdef CMD_CHKSUM_EN
    pulse_clr();
    send_byte(8'h10, 1, 1'b0);
    send_byte(8'h20, 1, 1'b0);
    send_byte(8'h30, 1, 1'b0);
    send_byte(8'h9F, 1, 1'b0);
    check("chk_good_cmd", 32'(io.cmd), 32'h102030);
    check("chk_good_rdy", 32'(io.cmd_rdy), 32'h1);
    chk_pulses = 0;
    send_byte(8'h40, 1, 1'b0);
    send_byte(8'h50, 1, 1'b0);
    send_byte(8'h60, 1, 1'b0);
    send_byte(8'h00, 1, 1'b0);
    idle(2);
    check("chk_bad_pulses", 32'(chk_pulses), 32'h1);
    check("chk_bad_cmd", 32'(io.cmd), 32'h102030);
    check("chk_bad_rdy", 32'(io.cmd_rdy), 32'h1);
    check("chk_bad_ovr", 32'(io.overrun), 32'h0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
